// File: rtl/lsm_pkg.sv
// Shared channel state encoding for load_store_multi.
// The HOLD_HI/HOLD_LO dwell states exist only when LSM_DWELL_EN is defined.
package lsm_pkg;
`ifdef LSM_DWELL_EN
    localparam int ST_W = 2;
    typedef enum logic [ST_W-1:0] {ST_UP, ST_DOWN, ST_HOLD_HI, ST_HOLD_LO} lsm_state_e;
`else
    localparam int ST_W = 1;
    typedef enum logic [ST_W-1:0] {ST_UP, ST_DOWN} lsm_state_e;
`endif
endpackage

// File: rtl/lsm_channel.sv
// One bounded triangle counter between runtime limits lo..hi.
// Optional turnaround dwell (LSM_DWELL_EN) uses a down-counter with terminal count at zero.
//
// state    | meaning
// ST_UP    | counting toward hi
// ST_DOWN  | counting toward lo
// ST_HOLD_HI | dwelling at hi before reversing (LSM_DWELL_EN only)
// ST_HOLD_LO | dwelling at lo before reversing (LSM_DWELL_EN only)
module lsm_channel
    import lsm_pkg::*;
#(
    parameter int CBITS = 13,
    parameter int N_DEF = 7500,
    parameter int DWELL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [CBITS-1:0] wr_hi,
    input  logic [CBITS-1:0] wr_lo,
    output logic [CBITS-1:0] vol,
    output logic             dir,
    output logic             at_hi,
    output logic             peak_pulse,
    output logic             trough_pulse
);
    lsm_state_e       state, state_n;
    logic [CBITS-1:0] hi, lo, vol_n, hi_n, lo_n;
    logic             at_hi_n, peak_n, trough_n;
`ifdef LSM_DWELL_EN
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    logic [DW_W-1:0] cnt, cnt_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_DOWN;
            vol          <= '0;
            hi           <= CBITS'(N_DEF);
            lo           <= '0;
            at_hi        <= 1'b0;
            peak_pulse   <= 1'b0;
            trough_pulse <= 1'b0;
`ifdef LSM_DWELL_EN
            cnt          <= '0;
`endif
        end else begin
            state        <= state_n;
            vol          <= vol_n;
            hi           <= hi_n;
            lo           <= lo_n;
            at_hi        <= at_hi_n;
            peak_pulse   <= peak_n;
            trough_pulse <= trough_n;
`ifdef LSM_DWELL_EN
            cnt          <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        vol_n    = vol;
        hi_n     = hi;
        lo_n     = lo;
        peak_n   = 1'b0;
        trough_n = 1'b0;
`ifdef LSM_DWELL_EN
        cnt_n    = cnt;
`endif
        if (wr) begin
            hi_n = wr_hi;
            lo_n = wr_lo;
            // Out-of-range count is pulled to the new floor and restarts upward
            if (vol < wr_lo || vol > wr_hi) begin
                vol_n   = wr_lo;
                state_n = ST_UP;
            end
        end else if (en) begin
            case (state)
                ST_UP: begin
                    if (vol >= hi) begin
`ifdef LSM_DWELL_EN
                        state_n = ST_HOLD_HI;
                        cnt_n   = DW_W'(DWELL - 1);
`else
                        state_n = ST_DOWN;
`endif
                        peak_n  = 1'b1;
                    end else begin
                        vol_n = vol + 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (vol <= lo) begin
`ifdef LSM_DWELL_EN
                        state_n = ST_HOLD_LO;
                        cnt_n   = DW_W'(DWELL - 1);
`else
                        state_n = ST_UP;
`endif
                        trough_n = 1'b1;
                    end else begin
                        vol_n = vol - 1'b1;
                    end
                end
`ifdef LSM_DWELL_EN
                ST_HOLD_HI: begin
                    if (cnt == '0) state_n = ST_DOWN;
                    else           cnt_n   = cnt - 1'b1;
                end
                ST_HOLD_LO: begin
                    if (cnt == '0) state_n = ST_UP;
                    else           cnt_n   = cnt - 1'b1;
                end
`endif
                default: state_n = ST_DOWN;
            endcase
        end
        at_hi_n = (vol_n == hi_n);
    end

`ifdef LSM_DWELL_EN
    assign dir = (state == ST_UP) || (state == ST_HOLD_LO);
`else
    assign dir = (state == ST_UP);
`endif
endmodule

// File: rtl/load_store_multi.sv
// NCH independent bounded triangle counters with a shared limit-write port.
// Define LSM_DWELL_EN to add DWELL-cycle holds at each turnaround.
module load_store_multi
    import lsm_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CBITS = 13,
    parameter int N_DEF = 7500,
    parameter int DWELL = 3
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NCH-1:0]                          en,
    input  logic                                    cfg_we,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
    input  logic [CBITS-1:0]                        cfg_hi,
    input  logic [CBITS-1:0]                        cfg_lo,
    output logic [NCH*CBITS-1:0]                    vol,
    output logic [NCH-1:0]                          dir,
    output logic [NCH-1:0]                          at_hi,
    output logic [NCH-1:0]                          peak_pulse,
    output logic [NCH-1:0]                          trough_pulse,
    output logic                                    cfg_err
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_bad;
    logic [NCH-1:0] wr;

    assign cfg_bad = (cfg_lo > cfg_hi) || (32'(cfg_ch) >= 32'(NCH));

    always_ff @(posedge clk) begin
        if (rst) cfg_err <= 1'b0;
        else     cfg_err <= cfg_we && cfg_bad;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr[i] = cfg_we && !cfg_bad && (cfg_ch == CHW'(i));

        lsm_channel #(
            .CBITS (CBITS),
            .N_DEF (N_DEF),
            .DWELL (DWELL)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .en           (en[i]),
            .wr           (wr[i]),
            .wr_hi        (cfg_hi),
            .wr_lo        (cfg_lo),
            .vol          (vol[i*CBITS +: CBITS]),
            .dir          (dir[i]),
            .at_hi        (at_hi[i]),
            .peak_pulse   (peak_pulse[i]),
            .trough_pulse (trough_pulse[i])
        );
    end
endmodule

// File: tb/tb_load_store_multi.sv
// Directed bench for load_store_multi in its default build (no dwell states).
module tb_load_store_multi;
    localparam int NCH = 4;
    localparam int CB  = 13;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  en = '0;
    logic            cfg_we = 1'b0;
    logic [1:0]      cfg_ch = '0;
    logic [CB-1:0]   cfg_hi = '0, cfg_lo = '0;
    logic [NCH*CB-1:0] vol;
    logic [NCH-1:0]  dir, at_hi, peak_pulse, trough_pulse;
    logic            cfg_err;

    int checks = 0;
    int failures = 0;

    load_store_multi dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .vol(vol), .dir(dir), .at_hi(at_hi),
        .peak_pulse(peak_pulse), .trough_pulse(trough_pulse), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    en;
        logic          we;
        logic [1:0]    ch;
        logic [CB-1:0] hi, lo;
        int            e_vol;
        logic          e_dir, e_ath, e_pk, e_tr, e_err;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(logic [3:0] e, logic w, logic [1:0] c, int h, int l,
                                int v, logic d, logic a, logic p, logic t, logic r);
        vec_t x;
        x.en = e; x.we = w; x.ch = c; x.hi = CB'(h); x.lo = CB'(l);
        x.e_vol = v; x.e_dir = d; x.e_ath = a; x.e_pk = p; x.e_tr = t; x.e_err = r;
        return x;
    endfunction

    function automatic int vol_of(int ch);
        return int'(vol[ch*CB +: CB]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = '0; cfg_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        // ch2 starts from vol=200 going UP; observe ch2 throughout
        tbl[0]  = mk(4'h4, 1, 2, 10, 5,  5, 1, 0, 0, 0, 0);
        tbl[1]  = mk(4'h4, 0, 0, 0, 0,   6, 1, 0, 0, 0, 0);
        tbl[2]  = mk(4'h4, 0, 0, 0, 0,   7, 1, 0, 0, 0, 0);
        tbl[3]  = mk(4'h4, 0, 0, 0, 0,   8, 1, 0, 0, 0, 0);
        tbl[4]  = mk(4'h4, 0, 0, 0, 0,   9, 1, 0, 0, 0, 0);
        tbl[5]  = mk(4'h4, 0, 0, 0, 0,  10, 1, 1, 0, 0, 0);
        tbl[6]  = mk(4'h4, 0, 0, 0, 0,  10, 0, 1, 1, 0, 0);
        tbl[7]  = mk(4'h4, 0, 0, 0, 0,   9, 0, 0, 0, 0, 0);
        tbl[8]  = mk(4'h4, 0, 0, 0, 0,   8, 0, 0, 0, 0, 0);
        tbl[9]  = mk(4'h4, 0, 0, 0, 0,   7, 0, 0, 0, 0, 0);
        tbl[10] = mk(4'h4, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0);
        tbl[11] = mk(4'h4, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0);
        tbl[12] = mk(4'h4, 0, 0, 0, 0,   5, 1, 0, 0, 1, 0);
        tbl[13] = mk(4'h4, 0, 0, 0, 0,   6, 1, 0, 0, 0, 0);
        tbl[14] = mk(4'h0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 0);
        tbl[15] = mk(4'h4, 1, 2, 3, 9,   7, 1, 0, 0, 0, 1);
        tbl[16] = mk(4'h4, 0, 0, 0, 0,   8, 1, 0, 0, 0, 0);
        tbl[17] = mk(4'h4, 0, 0, 0, 0,   9, 1, 0, 0, 0, 0);
        tbl[18] = mk(4'h4, 0, 0, 0, 0,  10, 1, 1, 0, 0, 0);
        tbl[19] = mk(4'h4, 0, 0, 0, 0,  10, 0, 1, 1, 0, 0);
        tbl[20] = mk(4'h4, 1, 2, 4, 4,   4, 1, 1, 0, 0, 0);
        tbl[21] = mk(4'h4, 0, 0, 0, 0,   4, 0, 1, 1, 0, 0);
        tbl[22] = mk(4'h4, 0, 0, 0, 0,   4, 1, 1, 0, 1, 0);
        tbl[23] = mk(4'h4, 0, 0, 0, 0,   4, 0, 1, 1, 0, 0);
        tbl[24] = mk(4'h4, 0, 0, 0, 0,   4, 1, 1, 0, 1, 0);
        tbl[25] = mk(4'h4, 1, 2, 20, 2,  4, 1, 0, 0, 0, 0);
        tbl[26] = mk(4'h4, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0);
        tbl[27] = mk(4'h4, 1, 1, 100, 0, 6, 1, 0, 0, 0, 0);

        // Reset values, then the full default ramp on all channels
        do_reset();
        rst = 1'b1; tick();
        chk("rst_vol", int'(vol), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_at_hi", int'(at_hi), 0);
        chk("rst_pulses", int'({peak_pulse, trough_pulse}), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0; en = 4'hF;
        tick();
        chk("first_trough", int'(trough_pulse), 4'hF);
        chk("first_dir", int'(dir), 4'hF);
        chk("first_vol0", vol_of(0), 0);
        for (int c = 2; c <= 15003; c++) begin
            tick();
            if (c == 7500) chk("pre_top_at_hi", int'(at_hi[0]), 0);
            if (c == 7501) begin
                chk("top_vol0", vol_of(0), 7500);
                chk("top_at_hi", int'(at_hi[0]), 1);
                chk("top_vol3", vol_of(3), 7500);
            end
            if (c == 7502) begin
                chk("peak0", int'(peak_pulse[0]), 1);
                chk("peak_dir0", int'(dir[0]), 0);
                chk("peak_vol0", vol_of(0), 7500);
            end
            if (c == 15002) chk("bottom_vol0", vol_of(0), 0);
            if (c == 15003) chk("bottom_trough0", int'(trough_pulse[0]), 1);
        end

        // en[1] frozen for 50 cycles mid-ramp
        do_reset();
        en = 4'hF;
        for (int c = 0; c < 100; c++) tick();
        chk("ramp_vol1", vol_of(1), 99);
        en = 4'b1101;
        for (int c = 0; c < 50; c++) tick();
        chk("freeze_vol1", vol_of(1), 99);
        chk("freeze_dir1", int'(dir[1]), 1);
        chk("freeze_vol0", vol_of(0), 149);
        chk("freeze_vol3", vol_of(3), 149);
        en = 4'hF;
        for (int c = 0; c < 10; c++) tick();
        chk("resume_vol1", vol_of(1), 109);
        chk("resume_vol0", vol_of(0), 159);

        // Reset beats a concurrent write and enable
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_hi = CB'(5); cfg_lo = CB'(2); rst = 1'b1;
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        chk("rst_ovr_vol", int'(vol), 0);
        chk("rst_ovr_dir", int'(dir), 0);
        en = 4'h1;
        for (int c = 1; c <= 7; c++) tick();
        chk("rst_ovr_limit_vol", vol_of(0), 6);
        chk("rst_ovr_limit_dir", int'(dir[0]), 1);

        // Ramp ch2 to 200 then run the table
        do_reset();
        en = 4'h4;
        for (int c = 0; c < 201; c++) tick();
        chk("pre_tbl_vol2", vol_of(2), 200);
        for (int i = 0; i < 28; i++) begin
            en = tbl[i].en; cfg_we = tbl[i].we; cfg_ch = tbl[i].ch;
            cfg_hi = tbl[i].hi; cfg_lo = tbl[i].lo;
            tick();
            chk($sformatf("tbl%0d_vol", i), vol_of(2), tbl[i].e_vol);
            chk($sformatf("tbl%0d_dir", i), int'(dir[2]), int'(tbl[i].e_dir));
            chk($sformatf("tbl%0d_at_hi", i), int'(at_hi[2]), int'(tbl[i].e_ath));
            chk($sformatf("tbl%0d_peak", i), int'(peak_pulse[2]), int'(tbl[i].e_pk));
            chk($sformatf("tbl%0d_trough", i), int'(trough_pulse[2]), int'(tbl[i].e_tr));
            chk($sformatf("tbl%0d_cfg_err", i), int'(cfg_err), int'(tbl[i].e_err));
        end
        cfg_we = 1'b0;
        chk("other_ch_idle_vol1", vol_of(1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
